// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low hex glyphs {g,f,e,d,c,b,a},
// capture FSM states and the glyph <-> nibble helpers.
package seg7_pkg;

  typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

  localparam logic [6:0] SegBlank = 7'b1111111;

  localparam logic [6:0] SegGlyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct packed {
    logic       hex;
    logic       blank;
    logic [3:0] nibble;
  } seg_dec_t;

  function automatic seg_dec_t seg_decode(input logic [6:0] seg);
    seg_dec_t d;
    d       = '0;
    d.blank = (seg == SegBlank);
    for (int i = 0; i < 16; i++) begin
      if (seg == SegGlyph[i]) begin
        d.hex    = 1'b1;
        d.nibble = 4'(i);
      end
    end
    return d;
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
    return SegGlyph[nibble];
  endfunction

endpackage

// File: rtl/seg7_scan_capture.sv
// Recovers the hex digits shown on a multiplexed 8-digit seven-segment display
// by waiting for each anode/segment pattern to settle and decoding it.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter bit          ERR_STICKY    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  AN,
  input  logic        CA,
  input  logic        CB,
  input  logic        CC,
  input  logic        CD,
  input  logic        CE,
  input  logic        CF,
  input  logic        CG,
  input  logic        clear,
  output logic [31:0] digits,
  output logic [7:0]  digit_valid,
  output logic        frame_done,
  output logic        seg_err
);

  localparam logic [7:0] StableCnt = 8'(STABLE_CYCLES);

  logic [7:0]  an_q;
  logic [6:0]  seg_q;
  logic [14:0] prev_q;
  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic [31:0] digits_q, digits_d;
  logic [7:0]  valid_q, valid_d, seen_q, seen_d;
  logic        fd_q, fd_d, err_q, err_d;
  logic        single, same, capture;
  logic [2:0]  idx;
  seg_dec_t    dec;

  assign single  = $onehot(~an_q);
  assign same    = ({an_q, seg_q} == prev_q);
  assign cnt_inc = cnt_q + 8'd1;
  assign dec     = seg_decode(seg_q);

  always_comb begin
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (!an_q[i]) idx = 3'(i);
    end
  end

  // Reset to "blank, no anode" so the first real sample is never mistaken for a repeat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q   <= '1;
      seg_q  <= '1;
      prev_q <= '1;
    end else begin
      an_q   <= AN;
      seg_q  <= {CG, CF, CE, CD, CC, CB, CA};
      prev_q <= {an_q, seg_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (single) begin
            state_d = StSettle;
            cnt_d   = 8'd1;
          end
        end
        StSettle: begin
          if (!same) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == StableCnt) state_d = StHold;
          end
        end
        StHold: begin
          if (!same) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    capture = (state_q == StSettle) && same && (cnt_inc == StableCnt) && !clear;
  end

  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    seen_d   = seen_q;
    fd_d     = 1'b0;
    err_d    = ERR_STICKY ? err_q : 1'b0;
    if (clear) begin
      digits_d = '0;
      valid_d  = '0;
      seen_d   = '0;
      err_d    = 1'b0;
    end else begin
      if (seen_q == 8'hFF) begin
        fd_d   = 1'b1;
        seen_d = '0;
      end
      if (capture) begin
        seen_d[idx] = 1'b1;
        if (dec.hex) begin
          digits_d[{idx, 2'b00} +: 4] = dec.nibble;
          valid_d[idx]                = 1'b1;
        end else begin
          valid_d[idx] = 1'b0;
          if (!dec.blank) err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= '0;
      valid_q  <= '0;
      seen_q   <= '0;
      fd_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      digits_q <= digits_d;
      valid_q  <= valid_d;
      seen_q   <= seen_d;
      fd_q     <= fd_d;
      err_q    <= err_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign frame_done  = fd_q;
  assign seg_err     = err_q;

endmodule
